sel_n_1_rr: RTL and testbench
=============================

SEL_N_1_RR -- requirements
Module: sel_n_1_rr

Interface
REQ-001 Parameter N, default 4, number of input channels (2..16).
REQ-002 Parameter W, default 8, data width per channel (1..32).
REQ-003 Parameter SW, default 2, select/channel-index width; 2^SW >= N SHALL hold.
REQ-004 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 DIN  input  N*W  channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-007 VLD  input  N  per-channel valid; bit k SHALL mean channel k holds a word.
REQ-008 ACK  output  N  one-hot pop strobe; bit k high SHALL mean channel k's word is taken this cycle.
REQ-009 MODE  input  1  0 = fixed select by SEL, 1 = round-robin scan.
REQ-010 SEL  input  SW  channel index used in fixed mode.
REQ-011 OUT  output  W  registered selected data.
REQ-012 OUT_CH  output  SW  registered index of the channel OUT came from.
REQ-013 OUT_VLD  output  1  OUT/OUT_CH hold a word.
REQ-014 OUT_RDY  input  1  downstream accepts OUT when OUT_VLD and OUT_RDY are both high.

Function
REQ-015 The block SHALL hold one output word register (OUT, OUT_CH, OUT_VLD).
REQ-016 Load enable LD SHALL be high when OUT_VLD=0 or (OUT_VLD=1 and OUT_RDY=1).
REQ-017 Fixed mode: candidate SHALL be channel SEL, granted only when SEL<N and VLD[SEL]=1; SEL>=N SHALL grant nothing.
REQ-018 Round-robin mode: candidate SHALL be the first k with VLD[k]=1 searching PTR, PTR+1, ... N-1, 0, ... PTR-1 (wrap-around).
REQ-019 A grant SHALL occur only when LD=1 and a candidate exists; ACK SHALL be the one-hot of the granted channel, combinational, in the grant cycle; otherwise ACK=0.
REQ-020 On a grant, next edge: OUT <= DIN slice of granted channel, OUT_CH <= granted index, OUT_VLD <= 1 (latency 1 cycle, VLD to OUT_VLD).
REQ-021 When LD=1 and no grant, next edge: OUT_VLD <= 0; OUT and OUT_CH SHALL hold their previous values.
REQ-022 When OUT_VLD=1 and OUT_RDY=0, OUT, OUT_CH, OUT_VLD SHALL remain stable and ACK SHALL be 0.
REQ-023 Simultaneous take and grant (OUT_VLD=1, OUT_RDY=1, candidate present) SHALL load the new word with no bubble cycle; full throughput one word per cycle.
REQ-024 Round-robin pointer PTR (SW bits) SHALL update to (granted+1) mod N on each round-robin grant; no grant SHALL leave PTR unchanged.
REQ-025 Fixed-mode grants SHALL NOT modify PTR.
REQ-026 MODE and SEL SHALL be sampled combinationally each cycle; a mode change SHALL take effect on the next grant decision without flushing OUT.
REQ-027 A channel whose VLD is high SHALL be granted within N load opportunities in round-robin mode (starvation freedom).

Reset
REQ-028 While RST_N=0: OUT=0, OUT_CH=0, OUT_VLD=0, PTR=0, ACK forced to 0, regardless of CLK.
REQ-029 Reset asserted mid-transfer SHALL discard the held word immediately; the first grant after deassertion SHALL search from channel 0.
REQ-030 Deassertion SHALL be honoured on the first rising CLK edge after RST_N goes high; no grant SHALL occur while RST_N=0.

Verification
REQ-031 Reset: RST_N=0 asynchronously mid-cycle with OUT_VLD=1 -> OUT_VLD=0, OUT=0, OUT_CH=0 before next edge.
REQ-032 Fixed: N=4, W=8, MODE=0, SEL=2, VLD=4'b0100, DIN ch2=8'hA5, OUT_RDY=1 -> ACK=4'b0100 that cycle; next cycle OUT=8'hA5, OUT_CH=2, OUT_VLD=1.
REQ-033 Fixed invalid: N=3, SW=2, SEL=3, VLD=3'b111 -> ACK=0, OUT_VLD stays 0.
REQ-034 Round-robin fairness: MODE=1, VLD=4'b1111 constant, OUT_RDY=1 -> OUT_CH sequence 0,1,2,3,0 on consecutive cycles, one ACK per cycle.
REQ-035 Wrap and skip: MODE=1, PTR=3 after grant of ch2, VLD=4'b0010 -> grant ch1, then PTR=2.
REQ-036 Backpressure: OUT_VLD=1, OUT_RDY=0 for 3 cycles with VLD=4'b1111 -> OUT/OUT_CH stable, ACK=0; OUT_RDY=1 -> take and new grant same cycle, no bubble.

Source files
------------

// File: rtl/sel_n_1_rr_if.sv
// Handshake bundle for the N-to-1 selector: per-channel data/valid/ack upstream,
// a single registered word with valid/ready downstream.
interface sel_n_1_rr_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 2
);
  logic [N*W-1:0] din;
  logic [N-1:0]   vld;
  logic [N-1:0]   ack;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out;
  logic [SW-1:0]  out_ch;
  logic           out_vld;
  logic           out_rdy;

  modport slave (
    input  din, vld, mode, sel, out_rdy,
    output ack, out, out_ch, out_vld
  );

  modport master (
    output din, vld, mode, sel, out_rdy,
    input  ack, out, out_ch, out_vld
  );
endinterface

// File: rtl/sel_n_1_rr.sv
// N-to-1 channel selector with fixed (SEL) or round-robin pick into a single
// registered output word; pops the chosen channel with a one-hot ACK.
module sel_n_1_rr #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 2
) (
  input logic           clk,
  input logic           rst_n,
  sel_n_1_rr_if.slave   bus
);

  logic [W-1:0]  out_q, out_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic          out_vld_q, out_vld_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          ld;
  logic          cand_vld;
  logic [SW-1:0] cand_idx;
  logic          gnt;
  logic [W-1:0]  cand_data;
  logic [SW:0]   rr_idx;

  // Register can accept a word when empty or being drained this cycle.
  assign ld = !out_vld_q || bus.out_rdy;

  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    rr_idx   = '0;
    if (!bus.mode) begin
      if (({1'b0, bus.sel} < (SW+1)'(N)) && bus.vld[bus.sel]) begin
        cand_vld = 1'b1;
        cand_idx = bus.sel;
      end
    end else begin
      // Descending offsets: the last hit written is the nearest one at or after ptr.
      for (int i = int'(N) - 1; i >= 0; i--) begin
        rr_idx = {1'b0, ptr_q} + (SW+1)'(i);
        if (rr_idx >= (SW+1)'(N)) begin
          rr_idx = rr_idx - (SW+1)'(N);
        end
        if (bus.vld[rr_idx[SW-1:0]]) begin
          cand_vld = 1'b1;
          cand_idx = rr_idx[SW-1:0];
        end
      end
    end
  end

  // No grant can slip through while reset is held.
  assign gnt = ld && cand_vld && rst_n;

  always_comb begin
    bus.ack   = '0;
    cand_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (cand_idx == SW'(k)) begin
        bus.ack[k] = gnt;
        cand_data  = bus.din[k*W +: W];
      end
    end
  end

  always_comb begin
    out_d     = out_q;
    out_ch_d  = out_ch_q;
    out_vld_d = out_vld_q;
    ptr_d     = ptr_q;
    if (gnt) begin
      out_d     = cand_data;
      out_ch_d  = cand_idx;
      out_vld_d = 1'b1;
      if (bus.mode) begin
        ptr_d = (cand_idx == SW'(N - 1)) ? '0 : cand_idx + 1'b1;
      end
    end else if (ld) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_ch_q  <= '0;
      out_vld_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      out_q     <= out_d;
      out_ch_q  <= out_ch_d;
      out_vld_q <= out_vld_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.out_ch  = out_ch_q;
  assign bus.out_vld = out_vld_q;

endmodule

// File: tb/tb_sel_n_1_rr.sv
// Bench for sel_n_1_rr: vector table, corner sequences (async reset, N=3 DUT)
// and random traffic against a behavioural model of the selection rules.
module tb_sel_n_1_rr;

  logic clk;
  logic rst_n;

  sel_n_1_rr_if #(.N(4), .W(8), .SW(2)) bus ();
  sel_n_1_rr_if #(.N(3), .W(8), .SW(2)) b3 ();

  sel_n_1_rr #(.N(4), .W(8), .SW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sel_n_1_rr #(.N(3), .W(8), .SW(2)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: output register contents and round-robin start point.
  bit         m_vld;
  logic [7:0] m_out;
  int         m_ch;
  int         m_ptr;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic [31:0] din;
    logic        rdy;
    logic [3:0]  ack;
    logic        ovld;
    logic [1:0]  och;
    logic [7:0]  oout;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_cand(input bit mode, input int sel, input logic [3:0] vld,
                                    input int ptr);
    if (!mode) begin
      if (sel < 4 && ((vld >> sel) & 4'd1) != 4'd0) return sel;
      return -1;
    end
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (ptr + k) % 4;
      if (((vld >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  // Checks this cycle's outputs against the model, then advances one clock.
  task automatic cycle(output logic [3:0] ack_seen);
    int         cand;
    bit         ld;
    bit         gnt;
    logic [3:0] exp_ack;
    #1;
    ld       = !m_vld || bus.out_rdy;
    cand     = model_cand(bus.mode, int'(bus.sel), bus.vld, m_ptr);
    gnt      = ld && cand >= 0;
    exp_ack  = gnt ? 4'(1 << cand) : 4'd0;
    ack_seen = bus.ack;
    check("ack", 32'(bus.ack), 32'(exp_ack));
    check("out_vld", 32'(bus.out_vld), 32'(m_vld));
    check("out_ch", 32'(bus.out_ch), 32'(m_ch));
    check("out", 32'(bus.out), 32'(m_out));
    if (gnt) begin
      m_out = 8'(bus.din >> (8 * cand));
      m_ch  = cand;
      m_vld = 1'b1;
      if (bus.mode) m_ptr = (cand + 1) % 4;
    end else if (ld) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_vld = 1'b0;
    m_out = '0;
    m_ch  = 0;
    m_ptr = 0;
  endtask

  initial begin
    logic [3:0]  a;
    logic [31:0] d3;
    logic [31:0] dd;

    dd = 32'h4433_2211;
    tbl[0]  = '{1'b0, 2'd2, 4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
    tbl[1]  = '{1'b0, 2'd3, 4'b0000, 32'h1122_3344, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA5};
    tbl[2]  = '{1'b1, 2'd0, 4'b1111, dd,            1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, dd,            1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, dd,            1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, dd,            1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
    tbl[6]  = '{1'b1, 2'd0, 4'b1111, dd,            1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    tbl[7]  = '{1'b1, 2'd0, 4'b1111, dd,            1'b0, 4'b0000, 1'b1, 2'd0, 8'h11};
    tbl[8]  = '{1'b1, 2'd0, 4'b1111, dd,            1'b0, 4'b0000, 1'b1, 2'd0, 8'h11};
    tbl[9]  = '{1'b1, 2'd0, 4'b1111, dd,            1'b0, 4'b0000, 1'b1, 2'd0, 8'h11};
    tbl[10] = '{1'b1, 2'd0, 4'b1111, dd,            1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    tbl[11] = '{1'b1, 2'd0, 4'b0100, dd,            1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
    tbl[12] = '{1'b1, 2'd0, 4'b0010, dd,            1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    tbl[13] = '{1'b1, 2'd0, 4'b1001, dd,            1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
    tbl[14] = '{1'b1, 2'd0, 4'b0000, dd,            1'b1, 4'b0000, 1'b0, 2'd3, 8'h44};
    tbl[15] = '{1'b0, 2'd1, 4'b0010, 32'hDEAD_BEEF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hBE};
    tbl[16] = '{1'b1, 2'd0, 4'b1111, dd,            1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};

    rst_n       = 1'b0;
    bus.din     = '0;
    bus.vld     = '0;
    bus.mode    = 1'b0;
    bus.sel     = '0;
    bus.out_rdy = 1'b0;
    b3.din      = '0;
    b3.vld      = '0;
    b3.mode     = 1'b0;
    b3.sel      = '0;
    b3.out_rdy  = 1'b0;
    model_reset();

    // Reset state, with valid traffic offered so ACK gating is exercised.
    bus.vld  = 4'b1111;
    bus.mode = 1'b1;
    #1;
    check("rst_ack", 32'(bus.ack), 32'h0);
    check("rst_out_vld", 32'(bus.out_vld), 32'h0);
    check("rst_out", 32'(bus.out), 32'h0);
    check("rst_out_ch", 32'(bus.out_ch), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    bus.vld  = '0;
    bus.mode = 1'b0;
    rst_n    = 1'b1;

    // N=3: out-of-range select grants nothing, then round-robin wraps at 3.
    d3         = $urandom;
    b3.din     = 24'(d3);
    b3.vld     = 3'b111;
    b3.sel     = 2'd3;
    b3.out_rdy = 1'b1;
    for (int j = 0; j < 2; j++) begin
      #1;
      check("n3_bad_sel_ack", 32'(b3.ack), 32'h0);
      @(posedge clk);
      #1;
      check("n3_bad_sel_vld", 32'(b3.out_vld), 32'h0);
    end
    b3.sel = 2'd1;
    #1;
    check("n3_sel1_ack", 32'(b3.ack), 32'h2);
    @(posedge clk);
    #1;
    check("n3_sel1_vld", 32'(b3.out_vld), 32'h1);
    check("n3_sel1_ch", 32'(b3.out_ch), 32'h1);
    check("n3_sel1_out", 32'(b3.out), 32'(d3[15:8]));
    b3.mode = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("n3_rr_ack", 32'(b3.ack), 32'(1 << (j % 3)));
      @(posedge clk);
      #1;
      check("n3_rr_ch", 32'(b3.out_ch), 32'(j % 3));
    end
    b3.vld  = '0;
    b3.mode = 1'b0;

    // Vector table on the N=4 instance.
    for (int i = 0; i < 17; i++) begin
      bus.mode    = tbl[i].mode;
      bus.sel     = tbl[i].sel;
      bus.vld     = tbl[i].vld;
      bus.din     = tbl[i].din;
      bus.out_rdy = tbl[i].rdy;
      cycle(a);
      check("tbl_ack", 32'(a), 32'(tbl[i].ack));
      check("tbl_out_vld", 32'(bus.out_vld), 32'(tbl[i].ovld));
      check("tbl_out_ch", 32'(bus.out_ch), 32'(tbl[i].och));
      check("tbl_out", 32'(bus.out), 32'(tbl[i].oout));
    end

    // Asynchronous reset mid-cycle while a word is held under backpressure.
    bus.vld     = 4'b1111;
    bus.mode    = 1'b1;
    bus.out_rdy = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_vld", 32'(bus.out_vld), 32'h0);
    check("async_rst_out", 32'(bus.out), 32'h0);
    check("async_rst_ch", 32'(bus.out_ch), 32'h0);
    check("async_rst_ack", 32'(bus.ack), 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_vld", 32'(bus.out_vld), 32'h0);
    check("rst_hold_ack", 32'(bus.ack), 32'h0);
    #1;
    rst_n = 1'b1;
    model_reset();
    bus.out_rdy = 1'b1;
    cycle(a);
    check("post_rst_first", 32'(a), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.mode    = ($urandom_range(0, 3) != 0);
      bus.sel     = 2'($urandom_range(0, 3));
      bus.vld     = 4'($urandom_range(0, 15));
      bus.din     = $urandom;
      bus.out_rdy = ($urandom_range(0, 3) != 0);
      cycle(a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
